wb_cmd_initiator: RTL
=====================

# wb_cmd_initiator

Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into one Wishbone bus cycle at a time and returns the result on a valid/ready response stream. It sits between a command source (debug UART bridge, test sequencer, boot loader) and the system Wishbone fabric, driving slaves such as the interrupt controller, timers and UARTs. A per-cycle timeout guarantees that an unmapped or hung slave cannot stall the command source.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before aborting; 0 disables the timeout.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  block can accept a command; high only in IDLE.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_adr  in  32  byte address.
- i_cmd_sel  in  4  byte lane selects.
- i_cmd_dat  in  32  write data.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_dat  out  32  read data; 0 for writes and for aborted cycles.
- o_rsp_status  out  2  00 OK, 01 ERR (slave err), 10 TIMEOUT.
- o_wb_adr / o_wb_sel / o_wb_we / o_wb_dat  out  32/4/1/32  registered Wishbone address, select, write enable and write data.
- o_wb_cyc, o_wb_stb  out  1  registered; always equal to each other.
- i_wb_dat  in  32  slave read data.
- i_wb_ack, i_wb_err  in  1  slave termination.

## Operation
- States are IDLE, BUS and RESP.
- **IDLE:**
  - o_cmd_ready=1.
  - On i_cmd_valid, latch we/adr/sel/dat into the o_wb_* registers, set cyc=stb=1, clear the timeout counter and go to BUS.
- **BUS:**
  - cyc/stb stay high; adr/sel/we/dat stay stable.
  - Each cycle, sample i_wb_ack/i_wb_err. On either:
    - deassert cyc/stb at the next edge and go to RESP;
    - status = ERR if i_wb_err, else OK;
    - o_rsp_dat = i_wb_dat if read with ack, else 0.
  - If neither is seen and the counter equals TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0):
    - deassert cyc/stb;
    - status = TIMEOUT, o_rsp_dat = 0;
    - go to RESP.
  - Otherwise increment the counter.
- **RESP:**
  - o_rsp_valid=1; o_rsp_dat and o_rsp_status are held.
  - When i_rsp_ready=1, go to IDLE.
- i_wb_ack/i_wb_err outside BUS are ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; the counter saturates and never wraps.

## Timing
- **Reset:**
  - All outputs are 0 (o_cmd_ready=0 while i_rst is high) and the state is IDLE.
  - Reset asserted mid-cycle drops cyc/stb immediately (asynchronously); no response is issued.
- **Latency:**
  - Command accepted at edge N → cyc/stb high in cycle N+1.
  - Ack seen in cycle N+1 (combinational slave ack) → o_rsp_valid high in cycle N+2 and cyc/stb low in N+2.
  - A slave acking k cycles after stb rises gives a response at N+2+k.
- **Minimum turnaround:** with i_rsp_ready held high, one command per 3 cycles (IDLE, BUS, RESP).
- **Simultaneous events:**
  - ack and err in the same cycle → ERR.
  - ack/err in the same cycle as the timeout limit → the slave termination wins (OK/ERR, not TIMEOUT).
- **Timeout:** cyc/stb are high for exactly TIMEOUT_CYCLES cycles before dropping.
- **Stable outputs:**
  - o_wb_* change only on the IDLE→BUS edge (adr/sel/we/dat) and the BUS→RESP edge (cyc/stb).
  - o_rsp_* are stable while o_rsp_valid=1 and i_rsp_ready=0.

## Structure
- Shared Wishbone package/include holds:
  - the response status constants WB_RSP_OK=2'd0, WB_RSP_ERR=2'd1, WB_RSP_TIMEOUT=2'd2;
  - the state encoding (IDLE/BUS/RESP).
- Single module; the timeout counter and FSM are small enough that no sub-module is warranted.

## Test plan
- **Write, combinational-ack slave:** cmd we=1, adr=0x1400_0008, sel=0xF, dat=0x0000_00A5, rsp_ready=1 → stb high 1 cycle with the same adr/dat, rsp_valid 2 cycles after accept, status=00, rsp_dat=0.
- **Read, registered-ack slave:** slave acks 1 cycle after stb with dat=0x2233_4455 → rsp_dat=0x2233_4455, status=00, stb high 2 cycles.
- **Slave err:** err on the first stb cycle → status=01, rsp_dat=0; ack+err together → status=01.
- **Timeout:** TIMEOUT_CYCLES=8, silent slave → cyc/stb high exactly 8 cycles, status=10, rsp_dat=0; ack on the 8th cycle → status=00.
- **Backpressure:** rsp_ready low for 5 cycles → rsp_valid, rsp_dat and rsp_status held, cmd_ready=0, no new bus cycle; back-to-back commands with rsp_ready=1 → one command per 3 cycles.
- **Reset mid-cycle:** assert i_rst while stb is high, slave stalled → cyc/stb low without waiting for an edge, no rsp_valid, cmd_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/wb_cmd_initiator_pkg.sv
// Shared Wishbone initiator definitions: response status codes, FSM encoding
// and the timeout counter sizing helper.
package wb_cmd_initiator_pkg;

    localparam logic [1:0] WB_RSP_OK      = 2'd0;
    localparam logic [1:0] WB_RSP_ERR     = 2'd1;
    localparam logic [1:0] WB_RSP_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } wb_state_e;

    // Counter must hold 0..timeout; a disabled timeout still needs one bit.
    function automatic int unsigned wb_cnt_width(input int unsigned timeout);
        if (timeout == 0) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle,
// one response out, with a per-cycle timeout against silent slaves.
module wb_cmd_initiator
    import wb_cmd_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [3:0]  i_cmd_sel,
    input  logic [31:0] i_cmd_dat,

    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic [1:0]  o_rsp_status,

    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    localparam int unsigned CNT_W = wb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    wb_state_e        r_state;
    wb_state_e        w_state_next;
    logic             r_wb_cyc;
    logic             w_wb_cyc_next;
    logic [31:0]      r_wb_adr;
    logic [31:0]      w_wb_adr_next;
    logic [3:0]       r_wb_sel;
    logic [3:0]       w_wb_sel_next;
    logic             r_wb_we;
    logic             w_wb_we_next;
    logic [31:0]      r_wb_dat;
    logic [31:0]      w_wb_dat_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      r_rsp_dat;
    logic [31:0]      w_rsp_dat_next;
    logic [1:0]       r_rsp_status;
    logic [1:0]       w_rsp_status_next;
    logic             w_term;
    logic             w_timeout;

    assign w_term    = i_wb_ack | i_wb_err;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT);

    always_comb begin
        w_state_next      = r_state;
        w_wb_cyc_next     = r_wb_cyc;
        w_wb_adr_next     = r_wb_adr;
        w_wb_sel_next     = r_wb_sel;
        w_wb_we_next      = r_wb_we;
        w_wb_dat_next     = r_wb_dat;
        w_cnt_next        = r_cnt;
        w_rsp_dat_next    = r_rsp_dat;
        w_rsp_status_next = r_rsp_status;

        unique case (r_state)
            StIdle: begin
                if (i_cmd_valid) begin
                    w_wb_adr_next = i_cmd_adr;
                    w_wb_sel_next = i_cmd_sel;
                    w_wb_we_next  = i_cmd_we;
                    w_wb_dat_next = i_cmd_dat;
                    w_wb_cyc_next = 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = StBus;
                end
            end
            StBus: begin
                // Slave termination takes priority over a coincident timeout.
                if (w_term) begin
                    w_wb_cyc_next     = 1'b0;
                    w_state_next      = StResp;
                    w_rsp_status_next = i_wb_err ? WB_RSP_ERR : WB_RSP_OK;
                    w_rsp_dat_next    = (!r_wb_we && !i_wb_err) ? i_wb_dat : 32'd0;
                end else if (w_timeout) begin
                    w_wb_cyc_next     = 1'b0;
                    w_state_next      = StResp;
                    w_rsp_status_next = WB_RSP_TIMEOUT;
                    w_rsp_dat_next    = 32'd0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next  = StIdle;
                w_wb_cyc_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_wb_cyc     <= 1'b0;
            r_wb_adr     <= 32'd0;
            r_wb_sel     <= 4'd0;
            r_wb_we      <= 1'b0;
            r_wb_dat     <= 32'd0;
            r_cnt        <= '0;
            r_rsp_dat    <= 32'd0;
            r_rsp_status <= WB_RSP_OK;
        end else begin
            r_state      <= w_state_next;
            r_wb_cyc     <= w_wb_cyc_next;
            r_wb_adr     <= w_wb_adr_next;
            r_wb_sel     <= w_wb_sel_next;
            r_wb_we      <= w_wb_we_next;
            r_wb_dat     <= w_wb_dat_next;
            r_cnt        <= w_cnt_next;
            r_rsp_dat    <= w_rsp_dat_next;
            r_rsp_status <= w_rsp_status_next;
        end
    end

    // State is already IDLE during reset, so ready must be masked explicitly.
    assign o_cmd_ready  = (r_state == StIdle) && !i_rst;
    assign o_rsp_valid  = (r_state == StResp);
    assign o_rsp_dat    = r_rsp_dat;
    assign o_rsp_status = r_rsp_status;
    assign o_wb_adr     = r_wb_adr;
    assign o_wb_sel     = r_wb_sel;
    assign o_wb_we      = r_wb_we;
    assign o_wb_dat     = r_wb_dat;
    assign o_wb_cyc     = r_wb_cyc;
    assign o_wb_stb     = r_wb_cyc;

endmodule
